// File: rtl/pe_cube_pkg.sv
// rtl/pe_cube_pkg.sv - shared constants, FSM state type and sign-extension helper for the PE cube psum collector
package pe_cube_pkg;

    localparam int NUM_ARRAY = 16;
    localparam int S1_W      = 21;
    localparam int S2_W      = 32;
    localparam int IDX_W     = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        DONE  = 2'd2
    } state_e;

    function automatic logic [S2_W-1:0] sext_s1(input logic [S1_W-1:0] v);
        return {{(S2_W-S1_W){v[S1_W-1]}}, v};
    endfunction

endpackage

// File: rtl/psum_acc_lane.sv
// rtl/psum_acc_lane.sv - one partial-sum bank entry: clear, strategy-2 capture, strategy-1 accumulate
// Optional macro PSUM_COLLECTOR_SATURATE_EN: saturate the strategy-1 add instead of wrapping.
module psum_acc_lane
    import pe_cube_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clear,
    input  logic            capture,
    input  logic            strategy_2_en,
    input  logic [S1_W-1:0] s1,
    input  logic [S2_W-1:0] s2,
    output logic [S2_W-1:0] value
);

    logic [S2_W-1:0] bank_q;
    logic [S2_W-1:0] base;
    logic [S2_W-1:0] addend;
    logic [S2_W-1:0] sum;
    logic [S2_W-1:0] acc_next;

    // A clear in the same cycle as a capture makes the capture start from zero.
    always_comb begin
        base     = clear ? '0 : bank_q;
        addend   = sext_s1(s1);
        sum      = base + addend;
        acc_next = sum;
`ifdef PSUM_COLLECTOR_SATURATE_EN
        if ((base[S2_W-1] == addend[S2_W-1]) && (sum[S2_W-1] != base[S2_W-1])) begin
            acc_next = base[S2_W-1] ? {1'b1, {(S2_W-1){1'b0}}} : {1'b0, {(S2_W-1){1'b1}}};
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bank_q <= '0;
        end else if (capture) begin
            bank_q <= strategy_2_en ? s2 : acc_next;
        end else if (clear) begin
            bank_q <= '0;
        end
    end

    assign value = bank_q;

endmodule

// File: rtl/pe_cube_psum_collector.sv
// rtl/pe_cube_psum_collector.sv - PE cube psum bank, tile-loop feedback and output drain stream
// Optional macro PSUM_COLLECTOR_SATURATE_EN: strategy-1 accumulation saturates instead of wrapping.
module pe_cube_psum_collector #(
    parameter int NUM_ARRAY = pe_cube_pkg::NUM_ARRAY,
    parameter int S1_W      = pe_cube_pkg::S1_W,
    parameter int S2_W      = pe_cube_pkg::S2_W,
    parameter int IDX_W     = pe_cube_pkg::IDX_W
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic                      i_clear,
    input  logic                      i_result_valid,
    input  logic                      i_result_last,
    input  logic                      i_strategy_2_en,
    input  logic [NUM_ARRAY*S1_W-1:0] i_result_s1,
    input  logic [NUM_ARRAY*S2_W-1:0] i_result_s2,
    output logic [NUM_ARRAY*S2_W-1:0] o_psum_last_tile,
    output logic                      o_out_valid,
    input  logic                      i_out_ready,
    output logic [S2_W-1:0]           o_out_data,
    output logic [IDX_W-1:0]          o_out_idx,
    output logic                      o_busy,
    output logic                      o_overflow
);

    import pe_cube_pkg::*;

    state_e           state_q;
    state_e           state_d;
    logic [IDX_W-1:0] idx_q;
    logic             overflow_q;
    logic             in_idle;
    logic             lane_capture;
    logic             lane_clear;
    logic             beat_accept;
    logic [S2_W-1:0]  bank [NUM_ARRAY];

    assign in_idle      = (state_q == IDLE);
    assign lane_capture = in_idle && i_result_valid;
    // DONE reuses the lane clear path to empty the bank for the next tile loop.
    assign lane_clear   = (in_idle && i_clear) || (state_q == DONE);
    assign beat_accept  = (state_q == DRAIN) && i_out_ready;

    for (genvar k = 0; k < NUM_ARRAY; k++) begin : g_lane
        psum_acc_lane u_lane (
            .clk           (i_clk),
            .rst_n         (i_rst_n),
            .clear         (lane_clear),
            .capture       (lane_capture),
            .strategy_2_en (i_strategy_2_en),
            .s1            (i_result_s1[k*S1_W +: S1_W]),
            .s2            (i_result_s2[k*S2_W +: S2_W]),
            .value         (bank[k])
        );
        assign o_psum_last_tile[k*S2_W +: S2_W] = bank[k];
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (beat_accept) begin
                idx_q <= idx_q + 1'b1;
            end else if (state_q != DRAIN) begin
                idx_q <= '0;
            end
            if (i_result_valid && !in_idle) begin
                overflow_q <= 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  if (i_result_valid && i_result_last) state_d = DRAIN;
            DRAIN: if (beat_accept && (idx_q == IDX_W'(NUM_ARRAY-1))) state_d = DONE;
            DONE:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        o_out_valid = (state_q == DRAIN);
        o_out_data  = (state_q == DRAIN) ? bank[idx_q] : '0;
        o_out_idx   = idx_q;
        o_busy      = (state_q != IDLE);
        o_overflow  = overflow_q;
    end

endmodule

// File: tb/tb_pe_cube_psum_collector.sv
// tb/tb_pe_cube_psum_collector.sv - directed self-checking bench for pe_cube_psum_collector
module tb_pe_cube_psum_collector;

    localparam int NA  = 16;
    localparam int S1W = 21;
    localparam int S2W = 32;
    localparam int IW  = 4;

    logic               clk;
    logic               rst_n;
    logic               clear;
    logic               result_valid;
    logic               result_last;
    logic               strategy_2_en;
    logic [NA*S1W-1:0]  result_s1;
    logic [NA*S2W-1:0]  result_s2;
    logic [NA*S2W-1:0]  psum_last_tile;
    logic               out_valid;
    logic               out_ready;
    logic [S2W-1:0]     out_data;
    logic [IW-1:0]      out_idx;
    logic               busy;
    logic               overflow;

    int vectors;
    int miscompares;

    pe_cube_psum_collector dut (
        .i_clk            (clk),
        .i_rst_n          (rst_n),
        .i_clear          (clear),
        .i_result_valid   (result_valid),
        .i_result_last    (result_last),
        .i_strategy_2_en  (strategy_2_en),
        .i_result_s1      (result_s1),
        .i_result_s2      (result_s2),
        .o_psum_last_tile (psum_last_tile),
        .o_out_valid      (out_valid),
        .i_out_ready      (out_ready),
        .o_out_data       (out_data),
        .o_out_idx        (out_idx),
        .o_busy           (busy),
        .o_overflow       (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_bank_all(input string name, input logic [S2W-1:0] exp);
        for (int k = 0; k < NA; k++) begin
            vectors++;
            if (psum_last_tile[k*S2W +: S2W] !== exp) begin
                miscompares++;
                $display("FAIL %s lane %0d: got %h expected %h", name, k, psum_last_tile[k*S2W +: S2W], exp);
            end
        end
    endtask

    task automatic load_s2_k100();
        for (int k = 0; k < NA; k++) result_s2[k*S2W +: S2W] = 32'(k * 100);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; clear = 0; result_valid = 0; result_last = 0;
        strategy_2_en = 0; result_s1 = '0; result_s2 = '0; out_ready = 0;
        repeat (3) @(posedge clk);
        #1;
        check_bank_all("reset_bank", 32'h0);
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b expected 0", busy); end
        vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL reset_overflow: got %b expected 0", overflow); end
        vectors++; if (out_data !== 32'h0 || out_idx !== 4'h0) begin miscompares++; $display("FAIL reset_out: got %h/%h expected 0/0", out_data, out_idx); end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_strategy2_capture();
        load_s2_k100();
        strategy_2_en = 1; result_valid = 1; result_last = 0;
        step();
        result_valid = 0;
        for (int k = 0; k < NA; k++) begin
            vectors++;
            if (psum_last_tile[k*S2W +: S2W] !== 32'(k * 100)) begin
                miscompares++;
                $display("FAIL s2_capture lane %0d: got %h expected %h", k, psum_last_tile[k*S2W +: S2W], 32'(k * 100));
            end
        end
        step();
        vectors++; if (busy !== 1'b0 || out_valid !== 1'b0) begin miscompares++; $display("FAIL s2_stays_idle: busy %b valid %b expected 0 0", busy, out_valid); end
        clear = 1;
        step();
        clear = 0;
        check_bank_all("clear_idle", 32'h0);
    endtask

    task automatic test_strategy1_accum();
        load_s2_k100();
        for (int k = 0; k < NA; k++) result_s1[k*S1W +: S1W] = 21'h1FFFFB;
        strategy_2_en = 1; result_valid = 1;
        step();
        // clear with capture: bank must restart from zero, not from k*100
        strategy_2_en = 0; clear = 1; result_valid = 1;
        step();
        clear = 0;
        check_bank_all("s1_clear_capture", 32'hFFFFFFFB);
        step();
        step();
        result_valid = 0;
        check_bank_all("s1_accum3", 32'hFFFFFFF1);
        clear = 1;
        step();
        clear = 0;
    endtask

    task automatic test_drain_ready_high();
        load_s2_k100();
        strategy_2_en = 1; result_valid = 1; result_last = 1; out_ready = 1;
        step();
        result_valid = 0; result_last = 0;
        for (int k = 0; k < NA; k++) begin
            vectors++;
            if (out_valid !== 1'b1 || out_idx !== 4'(k) || out_data !== 32'(k * 100) || busy !== 1'b1) begin
                miscompares++;
                $display("FAIL drain_beat %0d: valid %b idx %0d data %h busy %b expected 1 %0d %h 1",
                         k, out_valid, out_idx, out_data, busy, k, 32'(k * 100));
            end
            clear = (k == 3);
            step();
        end
        clear = 0;
        vectors++; if (out_valid !== 1'b0 || busy !== 1'b1) begin miscompares++; $display("FAIL done_state: valid %b busy %b expected 0 1", out_valid, busy); end
        step();
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL done_to_idle: busy %b expected 0", busy); end
        check_bank_all("bank_after_done", 32'h0);
        out_ready = 0;
    endtask

    task automatic test_drain_backpressure();
        logic [S2W-1:0] model [NA];
        int exp_idx;
        int beats;
        int cyc;
        for (int k = 0; k < NA; k++) begin
            model[k] = 32'(1000 + k * 7);
            result_s2[k*S2W +: S2W] = model[k];
        end
        strategy_2_en = 1; result_valid = 1; result_last = 1; out_ready = 0;
        step();
        result_valid = 0; result_last = 0;
        exp_idx = 0; beats = 0; cyc = 0;
        while (beats < NA && cyc < 80) begin
            out_ready = cyc[0];
            if (cyc == 5) begin
                result_valid = 1;
                result_s2 = '1;
            end else begin
                result_valid = 0;
            end
            vectors++;
            if (out_valid !== 1'b1 || out_idx !== 4'(exp_idx) || out_data !== model[exp_idx]) begin
                miscompares++;
                $display("FAIL bp_beat %0d cyc %0d: valid %b idx %0d data %h expected 1 %0d %h",
                         exp_idx, cyc, out_valid, out_idx, out_data, exp_idx, model[exp_idx]);
            end
            if (out_valid && out_ready) begin
                exp_idx++;
                beats++;
            end
            cyc++;
            step();
        end
        result_valid = 0; out_ready = 0;
        vectors++; if (beats !== NA) begin miscompares++; $display("FAIL bp_beat_count: got %0d expected %0d", beats, NA); end
        vectors++; if (overflow !== 1'b1) begin miscompares++; $display("FAIL bp_overflow: got %b expected 1", overflow); end
        vectors++; if (out_valid !== 1'b0 || busy !== 1'b1) begin miscompares++; $display("FAIL bp_done: valid %b busy %b expected 0 1", out_valid, busy); end
        step();
        check_bank_all("bp_bank_cleared", 32'h0);
    endtask

    task automatic test_saturate();
        logic [S2W-1:0] exp0;
        logic [S2W-1:0] exp1;
`ifdef PSUM_COLLECTOR_SATURATE_EN
        exp0 = 32'h7FFFFFFF;
        exp1 = 32'h80000000;
`else
        exp0 = 32'h80000010;
        exp1 = 32'h7FFFFFF0;
`endif
        result_s2 = '0;
        result_s2[0*S2W +: S2W] = 32'h7FFFFFF0;
        result_s2[1*S2W +: S2W] = 32'h80000010;
        strategy_2_en = 1; result_valid = 1;
        step();
        result_s1 = '0;
        result_s1[0*S1W +: S1W] = 21'h000020;
        result_s1[1*S1W +: S1W] = 21'h1FFFE0;
        result_s1[2*S1W +: S1W] = 21'h000020;
        strategy_2_en = 0;
        step();
        result_valid = 0;
        vectors++; if (psum_last_tile[0*S2W +: S2W] !== exp0) begin miscompares++; $display("FAIL sat_pos: got %h expected %h", psum_last_tile[0*S2W +: S2W], exp0); end
        vectors++; if (psum_last_tile[1*S2W +: S2W] !== exp1) begin miscompares++; $display("FAIL sat_neg: got %h expected %h", psum_last_tile[1*S2W +: S2W], exp1); end
        vectors++; if (psum_last_tile[2*S2W +: S2W] !== 32'h20) begin miscompares++; $display("FAIL sat_plain: got %h expected 00000020", psum_last_tile[2*S2W +: S2W]); end
        clear = 1;
        step();
        clear = 0;
    endtask

    task automatic test_reset_mid_drain();
        load_s2_k100();
        strategy_2_en = 1; result_valid = 1; result_last = 1; out_ready = 1;
        step();
        result_valid = 0; result_last = 0;
        step();
        step();
        #2;
        rst_n = 0;
        #1;
        vectors++; if (out_valid !== 1'b0 || busy !== 1'b0 || overflow !== 1'b0 || out_idx !== 4'h0) begin
            miscompares++;
            $display("FAIL mid_reset: valid %b busy %b ovf %b idx %0d expected 0 0 0 0", out_valid, busy, overflow, out_idx);
        end
        check_bank_all("mid_reset_bank", 32'h0);
        step();
        rst_n = 1;
        step();
        step();
        vectors++; if (out_valid !== 1'b0 || busy !== 1'b0) begin miscompares++; $display("FAIL no_resume: valid %b busy %b expected 0 0", out_valid, busy); end
        out_ready = 0;
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        test_reset();
        test_strategy2_capture();
        test_strategy1_accum();
        test_drain_ready_high();
        test_drain_backpressure();
        test_saturate();
        test_reset_mid_drain();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
